store_queue_gen: RTL and testbench
==================================

Name: store_queue_gen

Overview:
- Parametrised in-order store queue that sits between the load/store unit issue path and the data-memory port.
- Holds speculative stores until retirement, then drains released stores to memory in program order.
- Generalises the fixed 4-entry, 32-bit store buffer to configurable depth and width.
- Adds flush-rollback, load-conflict detection and optional store-to-load forwarding.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits; multiple of 8
ID_W, 3, instruction id width (matches id_t)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
enq_valid  in  1  store offered
enq_ready  out  1  queue can accept
enq_addr  in  ADDR_W  store address
enq_be  in  DATA_W/8  byte enables
enq_data  in  DATA_W  store data
enq_id  in  ID_W  instruction id of store
retire_valid  in  1  a store id retires
retire_id  in  ID_W  retiring id
flush  in  1  discard all non-released entries
out_valid  out  1  head store released, presented to memory
out_ready  in  1  memory accepts head
out_addr  out  ADDR_W  head address
out_be  out  DATA_W/8  head byte enables
out_data  out  DATA_W  head data
ld_check_valid  in  1  load address probe
ld_addr  in  ADDR_W  load address
ld_conflict  out  1  probe hits a valid entry (same word)
fwd_valid  out  1  forward data available
fwd_data  out  DATA_W  forwarded data
count  out  $clog2(DEPTH)+1  occupied entries
empty  out  1  count == 0
no_released_pending  out  1  no RELEASED entry present

Behaviour:
- Storage: circular buffer; head and tail pointers are $clog2(DEPTH)+1 bits, with the MSB used for wrap.
  - full = (count == DEPTH).
- Per-entry state: EMPTY -> PENDING (on enqueue) -> RELEASED (on retire) -> EMPTY (on dequeue).
  - PENDING -> EMPTY on flush.
- Reset (async, rst_n low):
  - head = tail = 0; all entries EMPTY.
  - Output values: count=0, empty=1, no_released_pending=1, out_valid=0, ld_conflict=0, fwd_valid=0, enq_ready=1 after deassertion.
  - Reset mid-operation discards all entries, including RELEASED ones.
- Enqueue:
  - enq_ready = !full & !flush.
  - Fires on enq_valid & enq_ready. Entry written at tail in state PENDING; tail increments.
  - A dequeue in the same cycle does not lift a full condition; ready is based on the current count.
- Retire:
  - retire_valid marks the PENDING entry whose id == retire_id as RELEASED on the next edge.
  - Ids are unique in flight; a retire with no match is ignored.
  - A retire in the same cycle as that id's enqueue is not seen. Callers retire at least one cycle after enqueue.
- Ordering invariant: RELEASED entries always form a contiguous prefix starting at head, because retirement is in order.
- Dequeue:
  - out_valid = head entry RELEASED.
  - out_* are driven combinationally from the head entry.
  - On out_valid & out_ready: head increments and the entry becomes EMPTY.
  - Zero-cycle latency from RELEASED to out_valid at head.
- Flush:
  - tail <= head_next + released_count_next. All PENDING entries become EMPTY; RELEASED entries are kept and still drain.
  - Same cycle as retire: the retire is applied first, so that entry survives.
  - Same cycle as dequeue: the dequeue is applied as well.
  - Enqueue is blocked during the flush cycle.
- Load check:
  - ld_conflict = ld_check_valid & any non-EMPTY entry with addr[ADDR_W-1:$clog2(DATA_W/8)] equal to the load's word address. Combinational.
- count updates: +1 on enqueue, -1 on dequeue; both in one cycle leaves it unchanged.
- Wrap-around: pointers wrap naturally at 2*DEPTH; there is no special case.

Optional Feature:
- STORE_QUEUE_FORWARD_EN defined:
  - fwd_valid = ld_conflict & the youngest matching entry has all byte enables set.
  - fwd_data = that entry's data.
  - "Youngest" means closest to tail, searched tail-1 down to head.
  - Partial youngest match gives fwd_valid=0 with ld_conflict=1.
- Macro undefined:
  - fwd_valid tied 0 and fwd_data tied 0.
  - No forwarding logic; ld_conflict is unchanged.

Test Plan:
- Reset, then enqueue ids 0..3 (addr 0x100,0x104,0x108,0x10C, be 0xF) with DEPTH=4 -> count=4, enq_ready=0, out_valid=0.
- Retire ids 0,1 on consecutive cycles with out_ready=1 -> out_addr 0x100 then 0x104, count drops to 2, no_released_pending=1 afterwards.
- Enqueue 3 stores, retire the first, flush in the same cycle as retiring the second -> 2 entries drain; tail rolls back; count=0 after drain; third store is never emitted.
- Fill, drain and refill 3 times (12 stores) -> outputs in exact program order across pointer wrap; no lost or duplicated entries.
- Store data 0xDEADBEEF, be=0xF, at 0x200; probe ld_addr 0x202 -> ld_conflict=1; fwd_valid=1 with fwd_data=0xDEADBEEF if STORE_QUEUE_FORWARD_EN, else fwd_valid=0. With be=0x3 -> fwd_valid=0 in both builds.
- Assert rst_n low while 2 RELEASED entries are present -> out_valid falls immediately (async); count=0, empty=1.

Source files
------------

// File: rtl/store_queue_gen.sv
// store_queue_gen: in-order store queue between the LSU issue path and the
// data-memory port. Stores are enqueued speculatively (PENDING), promoted to
// RELEASED when their id retires, and drained from the head in program order.
// A flush discards every PENDING entry and rolls the tail back to just past
// the last RELEASED entry; RELEASED entries still drain.
//
// Optional feature macro: STORE_QUEUE_FORWARD_EN
//   defined   -> store-to-load forwarding from the youngest matching entry
//                when that entry writes the whole word
//   undefined -> fwd_valid / fwd_data tied to 0
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   enq_valid/ready/addr/be/data/id store enqueue handshake
//   retire_valid, retire_id         in-order retirement of a store id
//   flush                           drop all PENDING entries
//   out_valid/ready/addr/be/data    head store presented to memory
//   ld_check_valid, ld_addr         load address probe
//   ld_conflict                     probe matches a live entry (same word)
//   fwd_valid, fwd_data             forwarded store data
//   count, empty, no_released_pending  occupancy status
`timescale 1ns/1ps

// One queue slot: lifecycle state plus payload, retire match and word compare.
module store_queue_gen_entry #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 3,
  parameter int OFF    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [ID_W-1:0]       i_id,
  input  logic                  i_deq,
  input  logic                  i_ret_v,
  input  logic [ID_W-1:0]       i_ret_id,
  input  logic                  i_flush,
  input  logic [ADDR_W-OFF-1:0] i_ld_waddr,
  output logic                  o_busy,
  output logic                  o_rel,
  output logic                  o_rel_nxt,
  output logic                  o_hit,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [DATA_W/8-1:0]   o_be,
  output logic [DATA_W-1:0]     o_data
);
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_PEND = 2'd1, S_REL = 2'd2} st_e;

  st_e                r_st, w_st_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W/8-1:0] r_be;
  logic [DATA_W-1:0]   r_data;
  logic [ID_W-1:0]     r_id;

  // Retire is checked before flush so a store retiring in the flush cycle survives.
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      S_EMPTY: if (i_wr) w_st_nxt = S_PEND;
      S_PEND: begin
        if (i_ret_v && (r_id == i_ret_id)) w_st_nxt = S_REL;
        else if (i_flush)                  w_st_nxt = S_EMPTY;
      end
      S_REL:   if (i_deq) w_st_nxt = S_EMPTY;
      default: w_st_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= S_EMPTY;
      r_addr <= '0;
      r_be   <= '0;
      r_data <= '0;
      r_id   <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (i_wr) begin
        r_addr <= i_addr;
        r_be   <= i_be;
        r_data <= i_data;
        r_id   <= i_id;
      end
    end
  end

  assign o_busy    = (r_st != S_EMPTY);
  assign o_rel     = (r_st == S_REL);
  assign o_rel_nxt = (w_st_nxt == S_REL);
  assign o_hit     = o_busy && (r_addr[ADDR_W-1:OFF] == i_ld_waddr);
  assign o_addr    = r_addr;
  assign o_be      = r_be;
  assign o_data    = r_data;
endmodule

module store_queue_gen #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [ADDR_W-1:0]        enq_addr,
  input  logic [DATA_W/8-1:0]      enq_be,
  input  logic [DATA_W-1:0]        enq_data,
  input  logic [ID_W-1:0]          enq_id,
  input  logic                     retire_valid,
  input  logic [ID_W-1:0]          retire_id,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W/8-1:0]      out_be,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     ld_check_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_conflict,
  output logic                     fwd_valid,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     no_released_pending
);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int OFF = $clog2(DATA_W/8);

  logic [PW-1:0] r_head, r_tail;
  logic [PW-1:0] w_head_nxt, w_tail_nxt, w_count, w_relcnt;
  logic [AW-1:0] w_hidx, w_tidx;
  logic          w_full, w_enq, w_deq;

  logic [DEPTH-1:0]                w_busy, w_rel, w_rel_nxt, w_hit;
  logic [DEPTH-1:0][ADDR_W-1:0]    w_addr;
  logic [DEPTH-1:0][DATA_W/8-1:0]  w_be;
  logic [DEPTH-1:0][DATA_W-1:0]    w_data;

  assign w_hidx  = r_head[AW-1:0];
  assign w_tidx  = r_tail[AW-1:0];
  assign w_count = r_tail - r_head;
  assign w_full  = (w_count == PW'(DEPTH));

  // Ready uses the current count only; a same-cycle dequeue does not open a slot.
  assign enq_ready = !w_full && !flush;
  assign w_enq     = enq_valid && enq_ready;
  assign w_deq     = out_valid && out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    store_queue_gen_entry #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .OFF(OFF)
    ) u_ent (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr       (w_enq && (w_tidx == AW'(g))),
      .i_addr     (enq_addr),
      .i_be       (enq_be),
      .i_data     (enq_data),
      .i_id       (enq_id),
      .i_deq      (w_deq && (w_hidx == AW'(g))),
      .i_ret_v    (retire_valid),
      .i_ret_id   (retire_id),
      .i_flush    (flush),
      .i_ld_waddr (ld_addr[ADDR_W-1:OFF]),
      .o_busy     (w_busy[g]),
      .o_rel      (w_rel[g]),
      .o_rel_nxt  (w_rel_nxt[g]),
      .o_hit      (w_hit[g]),
      .o_addr     (w_addr[g]),
      .o_be       (w_be[g]),
      .o_data     (w_data[g])
    );
  end

  if (OFF > 0) begin : g_lo
    logic w_unused_ld_lo;
    assign w_unused_ld_lo = ^ld_addr[OFF-1:0];
  end

  // Released entries are a contiguous prefix from head, so after a flush the
  // new tail is simply head + number of entries that will be RELEASED.
  always_comb begin
    w_relcnt = '0;
    for (int i = 0; i < DEPTH; i++) w_relcnt = w_relcnt + PW'(w_rel_nxt[i]);
  end

  assign w_head_nxt = r_head + PW'(w_deq);
  assign w_tail_nxt = flush ? (w_head_nxt + w_relcnt) : (r_tail + PW'(w_enq));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
    end
  end

  assign out_valid = w_rel[w_hidx];
  assign out_addr  = w_addr[w_hidx];
  assign out_be    = w_be[w_hidx];
  assign out_data  = w_data[w_hidx];

  assign ld_conflict = ld_check_valid && (|w_hit);

`ifdef STORE_QUEUE_FORWARD_EN
  // Walk oldest to youngest; the last hit seen is the youngest match.
  logic [AW-1:0] w_fsel;
  always_comb begin
    w_fsel = w_hidx;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_hit[AW'(w_hidx + AW'(k))]) w_fsel = AW'(w_hidx + AW'(k));
    end
  end
  assign fwd_valid = ld_conflict && (&w_be[w_fsel]);
  assign fwd_data  = w_data[w_fsel];
`else
  assign fwd_valid = 1'b0;
  assign fwd_data  = '0;
`endif

  assign count               = w_count;
  assign empty               = (w_count == '0);
  assign no_released_pending = ~|w_rel;

  logic w_unused_busy;
  assign w_unused_busy = ^w_busy;
endmodule

// File: tb/tb_store_queue_gen.sv
`timescale 1ns/1ps
module tb_store_queue_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enq_valid, enq_ready;
  logic [31:0] enq_addr, enq_data;
  logic [3:0]  enq_be;
  logic [2:0]  enq_id;
  logic        retire_valid;
  logic [2:0]  retire_id;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_addr, out_data;
  logic [3:0]  out_be;
  logic        ld_check_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict, fwd_valid;
  logic [31:0] fwd_data;
  logic [2:0]  count;
  logic        empty, no_released_pending;

  int n_chk = 0;
  int n_err = 0;

`ifdef STORE_QUEUE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  store_queue_gen #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .ID_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
    .enq_be(enq_be), .enq_data(enq_data), .enq_id(enq_id),
    .retire_valid(retire_valid), .retire_id(retire_id), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_be(out_be), .out_data(out_data),
    .ld_check_valid(ld_check_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data),
    .count(count), .empty(empty), .no_released_pending(no_released_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                     input logic [2:0] id);
    enq_valid = 1'b1; enq_addr = a; enq_be = be; enq_data = d; enq_id = id;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic retire(input logic [2:0] id);
    retire_valid = 1'b1; retire_id = id;
    tick();
    retire_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enq_valid = 1'b0; enq_addr = '0; enq_be = '0; enq_data = '0;
    enq_id = '0; retire_valid = 1'b0; retire_id = '0; flush = 1'b0;
    out_ready = 1'b0; ld_check_valid = 1'b0; ld_addr = '0;

    // Reset state
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_nrp", no_released_pending, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ld_conflict", ld_conflict, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_enq_ready", enq_ready, 1);

    // Fill to full
    for (int i = 0; i < 4; i++) enq(32'h100 + 32'(4*i), 4'hF, 32'hA0 + 32'(i), 3'(i));
    chk("full_count", count, 4);
    chk("full_enq_ready", enq_ready, 0);
    chk("full_out_valid", out_valid, 0);
    chk("full_empty", empty, 0);
    enq_valid = 1'b1; enq_addr = 32'h999; enq_id = 3'd7;
    tick();
    enq_valid = 1'b0;
    chk("full_drop_count", count, 4);

    // Retire two in a row and drain them
    out_ready = 1'b1;
    retire(3'd0);
    chk("ret0_out_valid", out_valid, 1);
    chk("ret0_out_addr", out_addr, 32'h100);
    chk("ret0_out_data", out_data, 32'hA0);
    retire_valid = 1'b1; retire_id = 3'd1;
    tick();
    retire_valid = 1'b0;
    chk("ret1_out_addr", out_addr, 32'h104);
    chk("ret1_count", count, 3);
    tick();
    chk("ret_count", count, 2);
    chk("ret_nrp", no_released_pending, 1);
    chk("ret_out_valid", out_valid, 0);

    // Flush with nothing released empties the queue
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush0_count", count, 0);
    chk("flush0_empty", empty, 1);

    // Retire + flush same cycle: two released entries survive, third is dropped
    out_ready = 1'b0;
    enq(32'h300, 4'hF, 32'hB4, 3'd4);
    enq(32'h304, 4'hF, 32'hB5, 3'd5);
    enq(32'h308, 4'hF, 32'hB6, 3'd6);
    retire(3'd4);
    retire_valid = 1'b1; retire_id = 3'd5; flush = 1'b1; #1;
    chk("flush_enq_ready", enq_ready, 0);
    tick();
    retire_valid = 1'b0; flush = 1'b0;
    chk("flush_count", count, 2);
    chk("flush_out_addr0", out_addr, 32'h300);
    out_ready = 1'b1; tick();
    chk("flush_out_addr1", out_addr, 32'h304);
    chk("flush_out_valid1", out_valid, 1);
    tick();
    chk("flush_drain_count", count, 0);
    chk("flush_drain_out_valid", out_valid, 0);
    tick();
    chk("flush_no_third", out_valid, 0);

    // Fill / drain three rounds across pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++)
        enq(32'h400 + 32'(4*(4*r+j)), 4'hF, 32'h1000 + 32'(4*r+j), 3'(j + 4*(r%2)));
      chk("wrap_full", count, 4);
      for (int j = 0; j < 4; j++) begin
        retire(3'(j + 4*(r%2)));
        chk("wrap_out_valid", out_valid, 1);
        chk("wrap_out_addr", out_addr, 32'h400 + 32'(4*(4*r+j)));
        chk("wrap_out_data", out_data, 32'h1000 + 32'(4*r+j));
        tick();
      end
      chk("wrap_drained", count, 0);
    end

    // Load conflict / forwarding
    out_ready = 1'b0;
    enq(32'h200, 4'hF, 32'hDEADBEEF, 3'd0);
    ld_check_valid = 1'b1; ld_addr = 32'h202; #1;
    chk("ld_conflict_hit", ld_conflict, 1);
    chk("ld_fwd_valid", fwd_valid, FWD);
    chk("ld_fwd_data", fwd_data, FWD ? 32'hDEADBEEF : 32'h0);
    ld_addr = 32'h204; #1;
    chk("ld_conflict_other_word", ld_conflict, 0);
    ld_check_valid = 1'b0; ld_addr = 32'h200; #1;
    chk("ld_conflict_novalid", ld_conflict, 0);
    ld_check_valid = 1'b1; ld_addr = 32'h202;
    enq(32'h200, 4'h3, 32'h12345678, 3'd1);
    chk("ld_partial_conflict", ld_conflict, 1);
    chk("ld_partial_fwd_valid", fwd_valid, 0);
    enq(32'h200, 4'hF, 32'hCAFEF00D, 3'd2);
    chk("ld_young_fwd_valid", fwd_valid, FWD);
    chk("ld_young_fwd_data", fwd_data, FWD ? 32'hCAFEF00D : 32'h0);

    // Async reset with two released entries present
    retire(3'd0);
    retire(3'd1);
    chk("prerst_out_valid", out_valid, 1);
    chk("prerst_count", count, 3);
    chk("prerst_nrp", no_released_pending, 0);
    #2 rst_n = 1'b0; #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_nrp", no_released_pending, 1);
    chk("arst_ld_conflict", ld_conflict, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post_rst_enq_ready", enq_ready, 1);
    tick();
    chk("post_rst_count", count, 0);
    chk("post_rst_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
